// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard controller: load-use stall/bubble, taken-branch flush, multi-cycle
// multiply freeze of the front end, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_mul_start,
  input  logic             branch_taken,
  input  logic             stall_cnt_clr,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned MulCntW = 5;
  localparam logic [MulCntW-1:0] MulLoad = MulCntW'(MUL_LATENCY - 1);
  localparam bit MulStalls = (MUL_LATENCY > 1);

  typedef enum logic [0:0] {StRun, StMulBusy} state_e;

  state_e             state_q, state_d;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic lu, ms, cnt_gt1;

  assign cnt_gt1 = (mul_cnt_q > MulCntW'(1));

  // ex_rd == 0 is x0 and never forwards a real value, so it cannot create a hazard.
  assign lu = ex_memRead && (ex_rd != 5'd0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign ms = ((state_q == StRun) && ex_mul_start && MulStalls) ||
              ((state_q == StMulBusy) && cnt_gt1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StRun;
      mul_cnt_q     <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      mul_cnt_q     <= mul_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    unique case (state_q)
      StRun: begin
        if (!branch_taken && ms) begin
          state_d   = StMulBusy;
          mul_cnt_d = MulLoad;
        end
      end
      StMulBusy: begin
        if (cnt_gt1) begin
          mul_cnt_d = mul_cnt_q - MulCntW'(1);
        end else begin
          state_d   = StRun;
          mul_cnt_d = '0;
        end
      end
      default: begin
        state_d   = StRun;
        mul_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (ms) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
          end else if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        StMulBusy: begin
          busy = 1'b1;
          // Final multiply cycle lets the pipeline advance.
          if (cnt_gt1) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_cnt_clr) begin
      stall_count_d = '0;
    end else if (!pc_write && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: default, MUL_LATENCY=1 and CNT_W=4 instances.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_memRead, ex_mul_start, branch_taken, stall_cnt_clr;

  logic        pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, busy;
  logic [31:0] stall_count;
  logic        l1_pc_write, l1_if_id_write, l1_if_id_flush, l1_id_ex_write, l1_id_ex_bubble;
  logic        l1_busy;
  logic [31:0] l1_stall_count;
  logic        c4_pc_write, c4_if_id_write, c4_if_id_flush, c4_id_ex_write, c4_id_ex_bubble;
  logic        c4_busy;
  logic [3:0]  c4_stall_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_mul_start(ex_mul_start), .branch_taken(branch_taken),
    .stall_cnt_clr(stall_cnt_clr), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
    .busy(busy), .stall_count(stall_count)
  );

  hazard_stall_ctrl #(.MUL_LATENCY(1), .CNT_W(32)) dut_l1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_mul_start(ex_mul_start), .branch_taken(branch_taken),
    .stall_cnt_clr(stall_cnt_clr), .pc_write(l1_pc_write), .if_id_write(l1_if_id_write),
    .if_id_flush(l1_if_id_flush), .id_ex_write(l1_id_ex_write),
    .id_ex_bubble(l1_id_ex_bubble), .busy(l1_busy), .stall_count(l1_stall_count)
  );

  hazard_stall_ctrl #(.MUL_LATENCY(4), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_memRead(ex_memRead), .ex_mul_start(ex_mul_start), .branch_taken(branch_taken),
    .stall_cnt_clr(stall_cnt_clr), .pc_write(c4_pc_write), .if_id_write(c4_if_id_write),
    .if_id_flush(c4_if_id_flush), .id_ex_write(c4_id_ex_write),
    .id_ex_bubble(c4_id_ex_bubble), .busy(c4_busy), .stall_count(c4_stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // pc, if_id_write, id_ex_write, flush, bubble, busy packed for compact checks.
  function automatic logic [5:0] ctl();
    return {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, busy};
  endfunction

  // Move to just after the next rising edge, then inputs may change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_memRead = 0;
    ex_mul_start = 0; branch_taken = 0; stall_cnt_clr = 0;
  endtask

  initial begin
    clr_in();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #3;
      chk($sformatf("rst_ctl%0d", i), {26'd0, ctl()}, {26'd0, 6'b000110});
      chk($sformatf("rst_cnt%0d", i), stall_count, 32'd0);
    end
    chk("rst_c4_cnt", {28'd0, c4_stall_count}, 32'd0);

    cyc(); reset = 1'b1; #3;
    chk("run_idle", {26'd0, ctl()}, {26'd0, 6'b111000});

    // Load-use on rs2
    cyc(); ex_memRead = 1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1; #3;
    chk("lu_ctl", {26'd0, ctl()}, {26'd0, 6'b001010});
    cyc(); ex_memRead = 0; #3;
    chk("lu_after", {26'd0, ctl()}, {26'd0, 6'b111000});
    chk("lu_cnt", stall_count, 32'd1);

    cyc(); ex_memRead = 1; ex_rd = 5'd0; id_rs2 = 5'd0; #3;
    chk("lu_x0", {31'd0, pc_write}, 32'd1);

    // Load-use on rs1
    cyc(); clr_in(); ex_memRead = 1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1; #3;
    chk("lu_rs1", {26'd0, ctl()}, {26'd0, 6'b001010});
    // Low bits match only: not a hazard
    cyc(); ex_rd = 5'h13; id_rs1 = 5'h03; #3;
    chk("lu_5bit", {31'd0, pc_write}, 32'd1);
    chk("cnt_pre_mul", stall_count, 32'd2);

    // Multiply, latency 4, start at T
    cyc(); clr_in(); ex_mul_start = 1; #3;
    chk("mul_t0", {26'd0, ctl()}, {26'd0, 6'b000000});
    chk("l1_t0", {30'd0, l1_pc_write, l1_busy}, 32'b10);
    cyc(); #3;
    chk("mul_t1", {26'd0, ctl()}, {26'd0, 6'b000001});
    chk("l1_t1", {30'd0, l1_pc_write, l1_busy}, 32'b10);
    cyc(); branch_taken = 1; #3;
    chk("mul_t2_br", {26'd0, ctl()}, {26'd0, 6'b000001});
    cyc(); branch_taken = 0; #3;
    chk("mul_t3", {26'd0, ctl()}, {26'd0, 6'b111001});
    chk("mul_cnt", stall_count, 32'd5);
    cyc(); ex_mul_start = 0; #3;
    chk("mul_t4", {26'd0, ctl()}, {26'd0, 6'b111000});

    // Branch beats both load-use and multiply
    cyc(); ex_mul_start = 1; branch_taken = 1;
    ex_memRead = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1; #3;
    chk("br_prio", {26'd0, ctl()}, {26'd0, 6'b111110});
    cyc(); clr_in(); #3;
    chk("br_stay_run", {26'd0, ctl()}, {26'd0, 6'b111000});
    chk("br_cnt", stall_count, 32'd5);

    // Back-to-back multiply then reset mid-multiply
    cyc(); ex_mul_start = 1;
    cyc(); cyc(); cyc(); #3;
    chk("b2b_t3", {26'd0, ctl()}, {26'd0, 6'b111001});
    cyc(); #3;
    chk("b2b_fresh", {26'd0, ctl()}, {26'd0, 6'b000000});
    chk("b2b_cnt", stall_count, 32'd8);
    cyc(); #3;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0; #1;
    chk("midrst_ctl", {26'd0, ctl()}, {26'd0, 6'b000110});
    chk("midrst_cnt", stall_count, 32'd0);
    cyc(); clr_in(); reset = 1'b1; #3;
    chk("postrst_ctl", {26'd0, ctl()}, {26'd0, 6'b111000});
    chk("postrst_cnt", stall_count, 32'd0);

    // Saturation: 20 continuous load-use stall cycles
    cyc(); ex_memRead = 1; ex_rd = 5'd3; id_rs2 = 5'd3; id_uses_rs2 = 1;
    for (int i = 0; i < 20; i++) cyc();
    #3;
    chk("sat_c4", {28'd0, c4_stall_count}, 32'd15);
    chk("sat_w32", stall_count, 32'd20);
    chk("sat_stall", {31'd0, pc_write}, 32'd0);
    stall_cnt_clr = 1;
    cyc(); #3;
    chk("clr_c4", {28'd0, c4_stall_count}, 32'd0);
    chk("clr_w32", stall_count, 32'd0);
    stall_cnt_clr = 0;
    cyc(); #3;
    chk("clr_then_inc", {28'd0, c4_stall_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Drives the enable and flush controls of the IF, IF/ID and ID/EX pipeline stages, i.e. the `write` and bubble inputs of the ID/EX pipeline register.
- Detects load-use hazards: one-cycle stall plus bubble.
- Applies taken-branch flushes.
- Freezes the front end while a multi-cycle multiply occupies EX.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MUL_LATENCY, 4, total EX cycles of a multiply; legal range 1..16. Value 1 means no stall.
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_rs1  input  5  rs1 of the instruction in ID.
- id_rs2  input  5  rs2 of the instruction in ID.
- id_uses_rs1  input  1  ID instruction reads rs1.
- id_uses_rs2  input  1  ID instruction reads rs2.
- ex_rd  input  5  rd of the instruction in EX (ID/EX rd_out).
- ex_memRead  input  1  EX instruction is a load (ID/EX memRead_out).
- ex_mul_start  input  1  EX instruction is a multi-cycle multiply.
- branch_taken  input  1  branch in EX resolved taken this cycle.
- stall_cnt_clr  input  1  synchronous clear of stall_count.
- pc_write  output  1  PC update enable.
- if_id_write  output  1  IF/ID register write enable.
- if_id_flush  output  1  IF/ID loads a NOP.
- id_ex_write  output  1  ID/EX register write enable (drives `write`).
- id_ex_bubble  output  1  ID/EX loads all-zero control (bubble).
- busy  output  1  high while in MUL_BUSY.
- stall_count  output  CNT_W  cycles with pc_write==0 since reset or last clear.

Behaviour:
- Reset is asynchronous and active-low (one clock; reset is asynchronous and active-low).
  - While reset==0: state=RUN, mul_cnt=0, stall_count=0.
  - Outputs are forced to pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1, id_ex_bubble=1, busy=0.
- Reset asserted mid-multiply aborts the multiply immediately. After release: state RUN, all counters 0.
- States: RUN, MUL_BUSY. Control outputs are combinational from state, mul_cnt and the inputs (same-cycle effect). State, mul_cnt and stall_count are registered.
- Load-use condition: lu = ex_memRead && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- Multiply-stall condition: ms = (RUN && ex_mul_start && MUL_LATENCY>1) || (MUL_BUSY && mul_cnt>1).
- RUN, output priority (highest first):
  - branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1, id_ex_write=1. Load-use and multiply are ignored, because the wrong-path ID instruction is squashed.
  - ms: pc_write=0, if_id_write=0, id_ex_write=0, no flush or bubble. Load mul_cnt=MUL_LATENCY-1 and go to MUL_BUSY.
  - lu: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_bubble=1. The stall lasts exactly one cycle; the next cycle re-evaluates with the bubble in EX.
  - Otherwise: pc_write=1, if_id_write=1, id_ex_write=1, no flush or bubble.
- MUL_BUSY:
  - busy=1. ex_mul_start is ignored (the held multiply keeps asserting it); branch_taken and lu are ignored.
  - Each cycle mul_cnt decrements.
  - mul_cnt>1: full freeze, as for ms.
  - mul_cnt==1: outputs equal the RUN "otherwise" case (pipeline advances); next state RUN, mul_cnt=0.
- Multiply timing: with ex_mul_start first seen in RUN at cycle T, the freeze covers T..T+MUL_LATENCY-2 (MUL_LATENCY-1 cycles) and the pipeline advances at T+MUL_LATENCY-1.
- A multiply immediately followed by another multiply gets a fresh ms in the RUN cycle after exit.
- stall_count:
  - Increments on each clk edge where pc_write==0 and reset==1.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr has priority over increment: the counter loads 0 that edge.
- ex_rd==0 never produces a hazard. The rs/rd comparisons are full 5-bit equality.

Test Plan:
- Reset held low 3 cycles, then released → during reset enables=0, flush/bubble=1, stall_count=0. First cycle after release with no hazards: all enables=1, flush/bubble=0.
- Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle (ex_memRead=0) normal; stall_count=1. Repeat with ex_rd=0 → no stall.
- Multiply, MUL_LATENCY=4: ex_mul_start=1 held at T..T+3 → freeze at T, T+1, T+2; advance at T+3; busy=1 at T+1..T+3; stall_count +3. With MUL_LATENCY=1 → no stall.
- Simultaneous: branch_taken=1 with lu=1 and ex_mul_start=1 in RUN → flush and bubble, no freeze, state stays RUN.
- Reset asserted low at T+1 of a multiply → outputs go to reset values immediately. After release: state RUN, busy=0, stall_count=0.
- Saturation with CNT_W=4: 20 stall cycles → stall_count=15. stall_cnt_clr during a stall cycle → 0 next edge.
